// File: rtl/mips_pkg.sv
// Shared opcode constants, state encoding and opcode classification
// helpers for the multi-cycle MIPS control path.
package mips_pkg;

  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  // Halt-class opcode: retires like a branch, no register write-back.
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic writes_reg(input logic [5:0] op);
    logic w;
    case (op)
      OP_J, OP_BEQ, OP_BNE, OP_HALT: w = 1'b0;
      default:                       w = 1'b1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Memory bus handshake between the sequencer (master) and the bus side.
interface mc_sequencer_if;
  logic mem_read;
  logic mem_write;
  logic mem_addr_sel;
  logic mem_waitrequest;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr_sel,
    input  mem_waitrequest
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr_sel,
    output mem_waitrequest
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/wb with bus stall
// timeout, halt on fetch from address 0 and sticky bus_error.
//
// state  | meaning
// IDLE   | out of reset, starts fetching next cycle
// FETCH  | instruction read at PC, waits out bus stalls
// DECODE | opcode settles in the instruction register
// EXEC   | ALU/branch retire, or hand off to MEM for loads/stores
// MEM    | data access at ALU address
// WB     | load data written back to the register file
// HALT   | terminal until reset (PC 0 or bus timeout)
module mc_sequencer
  import mips_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           pc,
  input  logic [5:0]            opcode,
  mc_sequencer_if.master        bus,
  output logic                  ir_load,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [2:0]            state,
  output logic                  active,
  output logic                  bus_error
);

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  state_t           state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic             stalled;
  logic             timeout;

  // A fetch from PC 0 is a halt request, never a bus access, so it cannot stall.
  assign stalled = bus.mem_waitrequest &&
                   (((state_q == ST_FETCH) && (pc != 32'd0)) || (state_q == ST_MEM));
  assign timeout = stalled && (wait_cnt == CNT_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      bus_error <= 1'b0;
    end else begin
      if (state_nx != state_q) begin
        wait_cnt <= '0;
      end else if (stalled && (wait_cnt != CNT_MAX)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (timeout) begin
        bus_error <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE:   state_nx = ST_FETCH;
      ST_FETCH: begin
        if (pc == 32'd0)               state_nx = ST_HALT;
        else if (timeout)              state_nx = ST_HALT;
        else if (!bus.mem_waitrequest) state_nx = ST_DECODE;
      end
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC:   state_nx = is_mem_op(opcode) ? ST_MEM : ST_FETCH;
      ST_MEM: begin
        if (timeout)                   state_nx = ST_HALT;
        else if (!bus.mem_waitrequest) state_nx = (opcode == OP_LW) ? ST_WB : ST_FETCH;
      end
      ST_WB:     state_nx = ST_FETCH;
      ST_HALT:   state_nx = ST_HALT;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_addr_sel = 1'b0;
    ir_load          = 1'b0;
    pc_write         = 1'b0;
    reg_write        = 1'b0;
    active           = (state_q != ST_IDLE) && (state_q != ST_HALT);
    case (state_q)
      ST_FETCH: begin
        if ((pc != 32'd0) && !timeout) begin
          bus.mem_read = 1'b1;
          ir_load      = !bus.mem_waitrequest;
        end
      end
      ST_EXEC: begin
        if (!is_mem_op(opcode)) begin
          pc_write  = 1'b1;
          reg_write = writes_reg(opcode);
        end
      end
      ST_MEM: begin
        bus.mem_addr_sel = 1'b1;
        if (!timeout) begin
          bus.mem_read  = (opcode == OP_LW);
          bus.mem_write = (opcode == OP_SW);
          pc_write      = (opcode == OP_SW) && !bus.mem_waitrequest;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: an instruction-level model expands each
// instruction into per-cycle stimulus and expected outputs; a monitor compares.
`timescale 1ns/1ps
module tb_mc_sequencer;

  localparam int WAIT_TIMEOUT = 16;
  localparam int CNT_W        = 5;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3,
                 S_MEM = 4, S_WB = 5, S_HALT = 6;
  localparam logic [5:0] M_LW = 6'h23, M_SW = 6'h2B, M_J = 6'h02,
                         M_BEQ = 6'h04, M_BNE = 6'h05, M_HLT = 6'h3F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = 32'd4;
  logic [5:0]  opcode = 6'd0;
  logic        ir_load, pc_write, reg_write, active, bus_error;
  logic [2:0]  state;

  mc_sequencer_if bus();

  mc_sequencer #(.WAIT_TIMEOUT(WAIT_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .opcode    (opcode),
    .bus       (bus),
    .ir_load   (ir_load),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .state     (state),
    .active    (active),
    .bus_error (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic rd, wr, sel, irl, pcw, rgw, act, err;
  } obs_t;

  typedef struct {
    bit          rst;
    logic [31:0] p;
    logic [5:0]  op;
    bit          wq;
    obs_t        exp;
  } cyc_t;

  cyc_t plan[$];
  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cycle  = 0;
  bit   m_err    = 1'b0;
  obs_t m_exp, m_act;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] rpc();
    logic [31:0] v;
    v = $urandom;
    if (v == 32'd0) v = 32'd4;
    return v;
  endfunction

  function automatic obs_t mk(int st, bit rd, bit wr, bit sel, bit irl, bit pcw, bit rgw);
    obs_t o;
    o.st  = 3'(st);
    o.rd  = rd;
    o.wr  = wr;
    o.sel = sel;
    o.irl = irl;
    o.pcw = pcw;
    o.rgw = rgw;
    o.act = (st != S_IDLE) && (st != S_HALT);
    o.err = m_err;
    return o;
  endfunction

  task automatic push(input bit rst, input logic [31:0] p, input logic [5:0] op,
                      input bit wq, input obs_t e);
    cyc_t c;
    c.rst = rst; c.p = p; c.op = op; c.wq = wq; c.exp = e;
    plan.push_back(c);
  endtask

  task automatic gen_reset(input int n);
    m_err = 1'b0;
    for (int i = 0; i < n; i++) push(1'b0, rpc(), 6'($urandom), rb(), mk(S_IDLE, 0, 0, 0, 0, 0, 0));
    push(1'b1, rpc(), 6'($urandom), rb(), mk(S_IDLE, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic gen_halt(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] p;
      p = (i % 3 == 0) ? 32'd0 : rpc();
      push(1'b1, p, 6'($urandom), rb(), mk(S_HALT, 0, 0, 0, 0, 0, 0));
    end
  endtask

  // One instruction: fw/mw are stall cycles in fetch/mem; cut abandons it mid-MEM.
  task automatic gen_instr(input logic [31:0] p, input logic [5:0] op, input int fw,
                           input int mw, input bit cut, output bit halted);
    bit is_ld, is_st, wb;
    halted = 1'b0;
    is_ld  = (op == M_LW);
    is_st  = (op == M_SW);
    wb     = !(op == M_J || op == M_BEQ || op == M_BNE || op == M_HLT);
    if (p == 32'd0) begin
      push(1'b1, p, op, rb(), mk(S_FETCH, 0, 0, 0, 0, 0, 0));
      halted = 1'b1;
      return;
    end
    for (int i = 0; i < fw; i++) begin
      if (i == WAIT_TIMEOUT) begin
        push(1'b1, p, op, 1'b1, mk(S_FETCH, 0, 0, 0, 0, 0, 0));
        m_err = 1'b1; halted = 1'b1;
        return;
      end
      push(1'b1, p, op, 1'b1, mk(S_FETCH, 1, 0, 0, 0, 0, 0));
    end
    push(1'b1, p, op, 1'b0, mk(S_FETCH, 1, 0, 0, 1, 0, 0));
    push(1'b1, p, op, rb(), mk(S_DECODE, 0, 0, 0, 0, 0, 0));
    if (is_ld || is_st) begin
      push(1'b1, p, op, rb(), mk(S_EXEC, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < mw; i++) begin
        if (i == WAIT_TIMEOUT) begin
          push(1'b1, p, op, 1'b1, mk(S_MEM, 0, 0, 1, 0, 0, 0));
          m_err = 1'b1; halted = 1'b1;
          return;
        end
        push(1'b1, p, op, 1'b1, mk(S_MEM, is_ld, is_st, 1, 0, 0, 0));
      end
      if (cut) return;
      push(1'b1, p, op, 1'b0, mk(S_MEM, is_ld, is_st, 1, 0, is_st, 0));
      if (is_ld) push(1'b1, p, op, rb(), mk(S_WB, 0, 0, 0, 0, 1, 1));
    end else begin
      push(1'b1, p, op, rb(), mk(S_EXEC, 0, 0, 0, 0, 1, wb));
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        m_exp = exp_q.pop_front();
        m_act = {state, bus.mem_read, bus.mem_write, bus.mem_addr_sel,
                 ir_load, pc_write, reg_write, active, bus_error};
        n_checks++;
        if (m_act !== m_exp) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got st=%0d rd/wr/sel/irl/pcw/rgw/act/err=%b, expected st=%0d %b",
                   n_cycle, m_act.st, m_act[7:0], m_exp.st, m_exp[7:0]);
        end
        n_checks++;
        if (bus.mem_read && bus.mem_write) begin
          n_fail++;
          $display("FAIL rd_wr_exclusive cycle %0d: got rd=%b wr=%b, expected not both", n_cycle,
                   bus.mem_read, bus.mem_write);
        end
        n_checks++;
        if (ir_load && (reg_write || pc_write)) begin
          n_fail++;
          $display("FAIL irl_exclusive cycle %0d: got irl=%b pcw=%b rgw=%b, expected irl alone",
                   n_cycle, ir_load, pc_write, reg_write);
        end
      end
    end
  end

  initial begin : driver
    bit   h;
    logic [5:0] ops[9];
    cyc_t c;
    ops = '{6'h00, M_LW, M_SW, M_J, M_BEQ, M_BNE, 6'h08, 6'h0D, M_HLT};
    bus.mem_waitrequest = 1'b0;

    gen_reset(3);
    gen_instr(32'd4, 6'h00, 0, 0, 0, h);
    gen_instr(rpc(), M_LW, 0, 2, 0, h);
    gen_instr(rpc(), M_SW, 1, 2, 0, h);
    gen_instr(rpc(), M_BEQ, 0, 0, 0, h);
    gen_instr(rpc(), M_J, 2, 0, 0, h);
    gen_instr(rpc(), M_BNE, 0, 0, 0, h);
    gen_instr(rpc(), M_HLT, 0, 0, 0, h);
    gen_instr(rpc(), 6'h08, 3, 0, 0, h);
    for (int i = 0; i < 150; i++) begin
      int fw, mw;
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, WAIT_TIMEOUT) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, WAIT_TIMEOUT) : $urandom_range(0, 3);
      gen_instr(rpc(), ops[$urandom_range(0, 8)], fw, mw, 0, h);
    end
    gen_instr(rpc(), 6'h00, WAIT_TIMEOUT - 1, 0, 0, h);
    gen_instr(rpc(), 6'h00, WAIT_TIMEOUT, 0, 0, h);
    gen_instr(rpc(), M_LW, 0, WAIT_TIMEOUT, 0, h);
    gen_instr(rpc(), M_SW, 0, WAIT_TIMEOUT, 0, h);
    gen_instr(rpc(), 6'h00, WAIT_TIMEOUT + 1, 0, 0, h);
    gen_halt(20);
    gen_reset(2);
    gen_instr(rpc(), M_LW, 1, WAIT_TIMEOUT + 1, 0, h);
    gen_halt(20);
    gen_reset(2);
    gen_instr(rpc(), M_SW, 0, WAIT_TIMEOUT + 1, 0, h);
    gen_halt(5);
    gen_reset(1);
    gen_instr(rpc(), 6'h00, 0, 0, 0, h);
    gen_instr(32'd0, 6'h00, 0, 0, 0, h);
    gen_halt(20);
    gen_reset(2);
    gen_instr(rpc(), M_LW, 0, 3, 1, h);
    gen_reset(2);
    gen_instr(32'd4, 6'h00, 0, 0, 0, h);
    for (int i = 0; i < 20; i++) gen_instr(rpc(), ops[$urandom_range(0, 8)], $urandom_range(0, 2),
                                           $urandom_range(0, 2), 0, h);

    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(posedge clk);
      #1;
      n_cycle++;
      rst_n               = c.rst;
      pc                  = c.p;
      opcode              = c.op;
      bus.mem_waitrequest = c.wq;
      exp_q.push_back(c.exp);
    end
    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
